ppu_compositor: RTL and testbench

- Parametrised pixel compositor/palette stage between the background/sprite pixel generators and ppu_vga.
- Merges one background pixel with SPR_CH sprite channels, applying left-column clipping and priority, then looks up the 32-entry palette RAM to produce the 6-bit system palette index.
- Owns palette RAM, including the CPU-side read/write port, and the sticky sprite-0 hit flag.
- Adds what the previous top-level mux lacked: multi-channel arbitration, clipping, greyscale, registered 2-stage pipeline and an explicit frame-start clear.

---
 rtl/ppu_pkg.sv | 10 +
 rtl/ppu_pal_ram.sv | 32 +++
 rtl/ppu_compositor.sv | 88 ++++++++
 tb/tb_ppu_compositor.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/ppu_pkg.sv
// ppu_pkg: shared widths, greyscale mask and palette address mirroring
package ppu_pkg;
   localparam int PRAM_A_W = 5;
   localparam int SYS_PAL_W = 6;
   localparam int IDX_W = 4;
   localparam logic [SYS_PAL_W-1:0] GREY_MASK = 6'h30;
   function automatic logic [PRAM_A_W-1:0] pram_mirror(input logic [PRAM_A_W-1:0] a);
      return (a[1:0] == 2'b00) ? {1'b0, a[3:0]} : a;
   endfunction
endpackage

// File: rtl/ppu_pal_ram.sv
// ppu_pal_ram: 32x6 palette RAM with mirrored CPU and render read ports
module ppu_pal_ram
   import ppu_pkg::*;
(
   input  logic                 clk_in,
   input  logic                 rst_in,
   input  logic [PRAM_A_W-1:0]  cpu_a_in,
   input  logic [SYS_PAL_W-1:0] cpu_d_in,
   input  logic                 cpu_wr_in,
   output logic [SYS_PAL_W-1:0] cpu_d_out,
   input  logic [PRAM_A_W-1:0]  ren_a_in,
   input  logic                 ren_en_in,
   input  logic [SYS_PAL_W-1:0] ren_mask_in,
   output logic [SYS_PAL_W-1:0] ren_d_out
);
   logic [SYS_PAL_W-1:0] mem_q [1<<PRAM_A_W];
   logic [SYS_PAL_W-1:0] cpu_q, ren_q;
   // storage plus both registered read ports; reads see pre-write contents
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         mem_q <= '{default: '0};
         cpu_q <= '0;
         ren_q <= '0;
      end else begin
         if (cpu_wr_in) mem_q[pram_mirror(cpu_a_in)] <= cpu_d_in;
         cpu_q <= mem_q[pram_mirror(cpu_a_in)];
         if (ren_en_in) ren_q <= mem_q[pram_mirror(ren_a_in)] & ren_mask_in;
      end
   end
   assign cpu_d_out = cpu_q;
   assign ren_d_out = ren_q;
endmodule

// File: rtl/ppu_compositor.sv
// ppu_compositor: background/sprite merge, clipping, priority, palette lookup and sprite-0 hit
module ppu_compositor
   import ppu_pkg::*;
#(
   parameter int SPR_CH = 1,
   parameter int CLIP_W = 8,
   parameter int X_W = 10
) (
   input  logic                  clk_in,
   input  logic                  rst_in,
   input  logic                  pix_pulse_in,
   input  logic [X_W-1:0]        nes_x_in,
   input  logic                  frame_start_in,
   input  logic [IDX_W-1:0]      bg_idx_in,
   input  logic [4*SPR_CH-1:0]   spr_idx_in,
   input  logic [SPR_CH-1:0]     spr_pri_in,
   input  logic                  spr_primary_in,
   input  logic                  bg_en_in,
   input  logic                  spr_en_in,
   input  logic                  bg_clip_in,
   input  logic                  spr_clip_in,
   input  logic                  greyscale_in,
   input  logic [PRAM_A_W-1:0]   pram_a_in,
   input  logic [SYS_PAL_W-1:0]  pram_d_in,
   input  logic                  pram_wr_in,
   output logic [SYS_PAL_W-1:0]  pram_d_out,
   output logic [SYS_PAL_W-1:0]  sys_palette_idx_out,
   output logic                  pix_valid_out,
   output logic                  spr0_hit_out
);
   logic                in_clip, bg_op, found, win_pri, hit_d, hit_q;
   logic [SPR_CH-1:0]   spr_op;
   logic [IDX_W-1:0]    win_idx;
   logic [PRAM_A_W-1:0] addr_d, addr_q;
   logic                vld_q, vld2_q, grey_q;
   assign in_clip = nes_x_in < X_W'(CLIP_W);
   // opacity, lowest-channel-wins arbitration, priority mux and hit next-state
   always_comb begin
      bg_op = bg_en_in && !(bg_clip_in && in_clip) && bg_idx_in[1:0] != 2'b00;
      spr_op = '0;
      found = 1'b0;
      win_pri = 1'b0;
      win_idx = '0;
      for (int n = SPR_CH - 1; n >= 0; n--) begin
         spr_op[n] = spr_en_in && !(spr_clip_in && in_clip) && spr_idx_in[4*n +: 2] != 2'b00;
         if (spr_op[n]) begin
            found = 1'b1;
            win_pri = spr_pri_in[n];
            win_idx = spr_idx_in[4*n +: 4];
         end
      end
      addr_d = (found && (!win_pri || !bg_op)) ? {1'b1, win_idx} : bg_op ? {1'b0, bg_idx_in} : '0;
      hit_d = frame_start_in ? 1'b0 :
              (pix_pulse_in && spr_primary_in && spr_op[0] && bg_op && nes_x_in != X_W'(255)) ? 1'b1 : hit_q;
   end
   // stage-1 address capture, valid pipeline and sticky hit flag
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         addr_q <= '0;
         grey_q <= 1'b0;
         vld_q <= 1'b0;
         vld2_q <= 1'b0;
         hit_q <= 1'b0;
      end else begin
         if (pix_pulse_in) begin
            addr_q <= addr_d;
            grey_q <= greyscale_in;
         end
         vld_q <= pix_pulse_in;
         vld2_q <= vld_q;
         hit_q <= hit_d;
      end
   end
   ppu_pal_ram u_ram (
      .clk_in      (clk_in),
      .rst_in      (rst_in),
      .cpu_a_in    (pram_a_in),
      .cpu_d_in    (pram_d_in),
      .cpu_wr_in   (pram_wr_in),
      .cpu_d_out   (pram_d_out),
      .ren_a_in    (addr_q),
      .ren_en_in   (vld_q),
      .ren_mask_in (grey_q ? GREY_MASK : {SYS_PAL_W{1'b1}}),
      .ren_d_out   (sys_palette_idx_out)
   );
   assign pix_valid_out = vld2_q;
   assign spr0_hit_out = hit_q;
endmodule

// File: tb/tb_ppu_compositor.sv
// tb_ppu_compositor: directed vectors with a queue scoreboard for the pixel path
module tb_ppu_compositor;
   logic clk = 1'b0, rst = 1'b1;
   logic pix_pulse = 0, frame_start = 0, primary = 0;
   logic [9:0] x = 0;
   logic [3:0] bg = 0, pri = 0;
   logic [15:0] spr = 0;
   logic bg_en = 1, spr_en = 1, bg_clip = 0, spr_clip = 0, grey = 0;
   logic [4:0] pa = 0;
   logic [5:0] pd = 0;
   logic pwr = 0;
   logic [5:0] pram_q, sys;
   logic valid, hit;
   typedef struct { logic [5:0] v; int c; string n; } exp_t;
   exp_t q[$];
   logic [5:0] m [32];
   logic [5:0] last_v = 0;
   int cyc = 0, total = 0, bad = 0;

   ppu_compositor #(.SPR_CH(4), .CLIP_W(8), .X_W(10)) dut (
      .clk_in(clk), .rst_in(rst), .pix_pulse_in(pix_pulse), .nes_x_in(x),
      .frame_start_in(frame_start), .bg_idx_in(bg), .spr_idx_in(spr), .spr_pri_in(pri),
      .spr_primary_in(primary), .bg_en_in(bg_en), .spr_en_in(spr_en), .bg_clip_in(bg_clip),
      .spr_clip_in(spr_clip), .greyscale_in(grey), .pram_a_in(pa), .pram_d_in(pd),
      .pram_wr_in(pwr), .pram_d_out(pram_q), .sys_palette_idx_out(sys),
      .pix_valid_out(valid), .spr0_hit_out(hit)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   function automatic logic [4:0] mir(input logic [4:0] a);
      return (a[1:0] == 2'b00) ? {1'b0, a[3:0]} : a;
   endfunction

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // monitor: every valid pulse must match the oldest expected pixel, in its cycle
   always @(negedge clk) begin
      if (valid === 1'b1) begin
         if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_valid: got %h expected none", sys);
         end else begin
            exp_t e;
            e = q.pop_front();
            total++;
            if (sys !== e.v || cyc != e.c) begin
               bad++;
               $display("FAIL %s: got %h at cycle %0d expected %h at cycle %0d", e.n, sys, cyc, e.v, e.c);
            end
            last_v = e.v;
         end
      end
   end

   task automatic wr(input logic [4:0] a, input logic [5:0] d);
      @(negedge clk);
      pa = a; pd = d; pwr = 1;
      @(negedge clk);
      pwr = 0;
      m[mir(a)] = d;
   endtask

   task automatic rd(input logic [4:0] a, input string nm);
      @(negedge clk);
      pa = a;
      @(negedge clk);
      chk(nm, {2'b0, pram_q}, {2'b0, m[mir(a)]});
   endtask

   task automatic pixel(input logic [3:0] b, input logic [15:0] s, input logic [3:0] p,
                        input logic prim, input logic [9:0] px, input logic g,
                        input logic [4:0] ea, input string nm);
      exp_t e;
      @(negedge clk);
      bg = b; spr = s; pri = p; primary = prim; x = px; grey = g; pix_pulse = 1;
      e.v = m[ea] & (g ? 6'h30 : 6'h3f);
      e.c = cyc + 2;
      e.n = nm;
      q.push_back(e);
      @(negedge clk);
      pix_pulse = 0; primary = 0; bg = 4'hF; spr = 16'hFFFF;
   endtask

   task automatic drain();
      for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
      if (q.size() != 0) begin
         total++;
         bad++;
         $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
         q.delete();
      end
   endtask

   initial begin
      for (int i = 0; i < 32; i++) m[i] = 6'h00;
      repeat (3) @(negedge clk);
      chk("reset_sys", {2'b0, sys}, 8'h00);
      chk("reset_valid", {7'b0, valid}, 8'h00);
      chk("reset_hit", {7'b0, hit}, 8'h00);
      chk("reset_pram", {2'b0, pram_q}, 8'h00);
      rst = 0;
      for (int a = 0; a < 32; a++)
         if (!(a >= 16 && a[1:0] == 2'b00)) wr(5'(a), 6'(a + 32));
      rd(5'h16, "cpu_rd_16");
      wr(5'h10, 6'h21);
      rd(5'h00, "mirror_10_to_00");
      chk("mirror_model", {2'b0, m[0]}, 8'h21);
      wr(5'h11, 6'h15);
      rd(5'h01, "no_alias_01");
      rd(5'h11, "cpu_rd_11");
      // priority
      pixel(4'h5, 16'h0006, 4'h0, 0, 10'd50, 0, 5'h16, "spr_front");
      pixel(4'h5, 16'h0006, 4'h1, 0, 10'd50, 0, 5'h05, "spr_behind");
      pixel(4'h4, 16'h0006, 4'h1, 0, 10'd50, 0, 5'h16, "spr_behind_bg_transp");
      // multi-channel arbitration
      pixel(4'h0, 16'h0A94, 4'h0, 0, 10'd50, 0, 5'h19, "ch1_wins");
      pixel(4'h0, 16'hC848, 4'h0, 0, 10'd50, 0, 5'h00, "all_transparent");
      // clipping
      spr_clip = 1;
      pixel(4'h1, 16'h0002, 4'h0, 0, 10'd7, 0, 5'h01, "clip_x7");
      pixel(4'h1, 16'h0002, 4'h0, 0, 10'd8, 0, 5'h12, "clip_x8");
      spr_clip = 0;
      bg_clip = 1;
      pixel(4'h1, 16'h0000, 4'h0, 0, 10'd3, 0, 5'h00, "bg_clip_x3");
      bg_clip = 0;
      bg_en = 0;
      pixel(4'h5, 16'h0000, 4'h0, 0, 10'd50, 0, 5'h00, "bg_disabled");
      bg_en = 1;
      drain();
      repeat (3) @(negedge clk);
      chk("hold_value", {2'b0, sys}, {2'b0, last_v});
      chk("valid_is_pulse", {7'b0, valid}, 8'h00);
      // sprite-0 hit
      chk("hit_clear_before", {7'b0, hit}, 8'h00);
      pixel(4'h1, 16'h0002, 4'h0, 1, 10'd255, 0, 5'h12, "hit_x255_pix");
      chk("hit_x255", {7'b0, hit}, 8'h00);
      pixel(4'h1, 16'h0002, 4'h0, 1, 10'd100, 0, 5'h12, "hit_pix");
      chk("hit_set", {7'b0, hit}, 8'h01);
      repeat (4) @(negedge clk);
      chk("hit_held", {7'b0, hit}, 8'h01);
      frame_start = 1;
      @(negedge clk);
      frame_start = 0;
      chk("hit_frame_clear", {7'b0, hit}, 8'h00);
      frame_start = 1;
      pixel(4'h1, 16'h0002, 4'h0, 1, 10'd100, 0, 5'h12, "hit_clear_wins_pix");
      frame_start = 0;
      chk("hit_clear_wins", {7'b0, hit}, 8'h00);
      pixel(4'h1, 16'h0002, 4'h1, 1, 10'd100, 0, 5'h01, "hit_pri_ignored_pix");
      chk("hit_pri_ignored", {7'b0, hit}, 8'h01);
      // greyscale
      wr(5'h00, 6'h2D);
      pixel(4'h0, 16'h0000, 4'h0, 0, 10'd50, 1, 5'h00, "greyscale");
      pixel(4'h1, 16'h0002, 4'h0, 0, 10'd100, 0, 5'h12, "pre_reset_pix");
      drain();
      chk("pre_reset_sys", {2'b0, sys}, 8'h32);
      // async reset mid-stream
      pa = 5'h12;
      @(posedge clk);
      #3 rst = 1;
      #1;
      chk("async_rst_sys", {2'b0, sys}, 8'h00);
      chk("async_rst_hit", {7'b0, hit}, 8'h00);
      chk("async_rst_pram", {2'b0, pram_q}, 8'h00);
      for (int i = 0; i < 32; i++) m[i] = 6'h00;
      @(negedge clk);
      rst = 0;
      rd(5'h12, "ram_cleared");
      wr(5'h05, 6'h0B);
      pixel(4'h5, 16'h0000, 4'h0, 0, 10'd50, 0, 5'h05, "post_reset_pix");
      drain();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end
endmodule
